// File: rtl/ovrd_gain_sequencer.sv
// ---------------------------------------------------------------------------
// ovrd_gain_sequencer
//
// Produces the i_gain word for the overdrive stage. The live gain never jumps.
// It moves toward an effective target by at most one step per audio sample
// strobe. After reaching the target it waits a few sample strobes so the
// gain/clamp pipeline can flush, then pulses done. When the effect is
// disabled, the effective target becomes unity, which gives a soft bypass.
//
// Ports
//   clk             clock
//   rst             asynchronous active-high reset
//   i_sample_valid  one-cycle strobe per audio sample; gain moves only on it
//   i_enable        1: target = configured gain, 0: target = unity
//   i_cfg_valid     configuration request (target gain + step)
//   i_cfg_gain      requested target gain, unsigned fixed point
//   i_cfg_step      ramp increment per sample, unsigned fixed point (0 -> 1)
//   o_cfg_ready     configuration accepted when high (IDLE or SETTLE)
//   o_gain          registered live gain
//   o_busy          ramping or settling
//   o_done          one-cycle pulse when the sequence completes
// ---------------------------------------------------------------------------
module ovrd_gain_sequencer #(
    parameter int unsigned          fxp_size           = 16,
    parameter int unsigned          bits_per_gain_frac = 4,
    parameter logic [fxp_size-1:0]  max_gain           = 16'h0400,
    parameter int unsigned          settle_samples     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_sample_valid,
    input  logic                i_enable,
    input  logic                i_cfg_valid,
    input  logic [fxp_size-1:0] i_cfg_gain,
    input  logic [fxp_size-1:0] i_cfg_step,
    output logic                o_cfg_ready,
    output logic [fxp_size-1:0] o_gain,
    output logic                o_busy,
    output logic                o_done
);

    localparam logic [fxp_size-1:0] ONE   = {{(fxp_size-1){1'b0}}, 1'b1};
    localparam logic [fxp_size-1:0] UNITY = ONE << bits_per_gain_frac;
    localparam int unsigned         CNT_W = (settle_samples < 2) ? 1 : $clog2(settle_samples + 1);
    localparam logic [CNT_W-1:0]    SETTLE_LOAD = CNT_W'(settle_samples);
    localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAMP_UP,
        S_RAMP_DOWN,
        S_SETTLE
    } state_t;

    state_t                state_q, state_d;
    logic [fxp_size-1:0]   gain_q, gain_d;
    logic [fxp_size-1:0]   target_q, target_d;
    logic [fxp_size-1:0]   step_q, step_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;

    logic [fxp_size-1:0]   eff;
    logic                  cfg_ready;
    logic                  accept;
    logic                  eff_above;
    logic                  eff_below;
    logic [fxp_size:0]     up_diff;
    logic [fxp_size:0]     dn_diff;
    logic [fxp_size:0]     up_sum;
    logic [fxp_size-1:0]   gain_step;
    logic [fxp_size-1:0]   next_gain;

    // Upward sums are formed one bit wider; anything above max_gain is
    // clipped so the live gain can never leave the legal range.
    function automatic logic [fxp_size-1:0] sat_gain(input logic [fxp_size:0] v);
        if (v > {1'b0, max_gain}) begin
            sat_gain = max_gain;
        end else begin
            sat_gain = v[fxp_size-1:0];
        end
    endfunction

    // Candidate gain after one sample step toward eff. The final step is
    // shortened so the ramp lands exactly on eff and never overshoots.
    always_comb begin
        eff       = i_enable ? target_q : UNITY;
        eff_above = (eff > gain_q);
        eff_below = (eff < gain_q);
        up_diff   = {1'b0, eff} - {1'b0, gain_q};
        dn_diff   = {1'b0, gain_q} - {1'b0, eff};
        up_sum    = {1'b0, gain_q} + {1'b0, step_q};
        gain_step = gain_q;
        if (eff_above) begin
            if (up_diff <= {1'b0, step_q}) begin
                gain_step = eff;
            end else begin
                gain_step = sat_gain(up_sum);
            end
        end else if (eff_below) begin
            if (dn_diff <= {1'b0, step_q}) begin
                gain_step = eff;
            end else begin
                gain_step = gain_q - step_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gain_d    = gain_q;
        target_d  = target_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        next_gain = gain_q;
        cfg_ready = (state_q == S_IDLE) || (state_q == S_SETTLE);
        accept    = i_cfg_valid && cfg_ready;

        case (state_q)
            S_IDLE: begin
                if (eff_above) begin
                    state_d = S_RAMP_UP;
                end else if (eff_below) begin
                    state_d = S_RAMP_DOWN;
                end
            end

            // Both ramp states share one body: the direction is taken from
            // eff versus gain on every cycle, so an enable toggle flips the
            // ramp immediately without waiting for a strobe.
            S_RAMP_UP, S_RAMP_DOWN: begin
                next_gain = i_sample_valid ? gain_step : gain_q;
                gain_d    = next_gain;
                if (next_gain == eff) begin
                    if (settle_samples == 0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end
                end else if (next_gain < eff) begin
                    state_d = S_RAMP_UP;
                end else begin
                    state_d = S_RAMP_DOWN;
                end
            end

            // A target change aborts settling before the strobe count is
            // considered, so an abort never produces a done pulse.
            S_SETTLE: begin
                if (eff_above) begin
                    state_d = S_RAMP_UP;
                end else if (eff_below) begin
                    state_d = S_RAMP_DOWN;
                end else if (i_sample_valid) begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registers load at the edge, so a strobe in the accept cycle still
        // ramps with the previous target and step.
        if (accept) begin
            target_d = (i_cfg_gain > max_gain) ? max_gain : i_cfg_gain;
            step_d   = (i_cfg_step == '0) ? ONE : i_cfg_step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gain_q   <= UNITY;
            target_q <= UNITY;
            step_q   <= ONE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gain_q   <= gain_d;
            target_q <= target_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign o_cfg_ready = cfg_ready;
    assign o_gain      = gain_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = done_q;

endmodule

// File: tb/tb_ovrd_gain_sequencer.sv
module tb_ovrd_gain_sequencer;

    localparam int UNITY_G  = 16;
    localparam int MAX_G    = 1024;
    localparam int SETTLE_N = 2;

    logic        clk;
    logic        rst;
    logic        sv;
    logic        en;
    logic        cv;
    logic [15:0] cg;
    logic [15:0] cs;
    logic        ready;
    logic [15:0] gain;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    ovrd_gain_sequencer #(
        .fxp_size(16),
        .bits_per_gain_frac(4),
        .max_gain(16'h0400),
        .settle_samples(SETTLE_N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_sample_valid(sv),
        .i_enable(en),
        .i_cfg_valid(cv),
        .i_cfg_gain(cg),
        .i_cfg_step(cs),
        .o_cfg_ready(ready),
        .o_gain(gain),
        .o_busy(busy),
        .o_done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 = idle, 1 = moving toward target, 2 = settling
    int m_gain, m_tgt, m_step, m_phase, m_cnt;
    bit m_done;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gain = UNITY_G; m_tgt = UNITY_G; m_step = 1;
        m_phase = 0; m_cnt = 0; m_done = 0;
    endtask

    function automatic int toward(input int g, input int e, input int s);
        if (e > g) return g + (((e - g) < s) ? (e - g) : s);
        return g - (((g - e) < s) ? (g - e) : s);
    endfunction

    task automatic model_edge();
        int eff;
        bit acc;
        eff = en ? m_tgt : UNITY_G;
        acc = cv && (m_phase != 1);
        m_done = 0;
        if (m_phase == 0) begin
            if (eff != m_gain) m_phase = 1;
        end else if (m_phase == 1) begin
            if (sv) m_gain = toward(m_gain, eff, m_step);
            if (m_gain == eff) begin
                if (SETTLE_N == 0) begin m_phase = 0; m_done = 1; end
                else begin m_phase = 2; m_cnt = SETTLE_N; end
            end
        end else begin
            if (eff != m_gain) m_phase = 1;
            else if (sv) begin
                m_cnt--;
                if (m_cnt == 0) begin m_phase = 0; m_done = 1; end
            end
        end
        if (acc) begin
            m_tgt  = (int'(cg) > MAX_G) ? MAX_G : int'(cg);
            m_step = (cs == 0) ? 1 : int'(cs);
        end
    endtask

    // One clock edge: advance the model with the inputs the DUT sampled,
    // then compare all outputs shortly after the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check("gain",  gain,  m_gain);
        check("ready", ready, (m_phase != 1) ? 1 : 0);
        check("busy",  busy,  (m_phase != 0) ? 1 : 0);
        check("done",  done,  m_done ? 1 : 0);
    endtask

    task automatic strobe_wait(input int idle);
        repeat (idle) tick();
        sv = 1'b1;
        tick();
        sv = 1'b0;
    endtask

    // Asynchronous reset asserted between clock edges; outputs must return
    // to reset values without waiting for an edge.
    task automatic do_reset();
        sv = 1'b0; cv = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_gain",  gain,  UNITY_G);
        check("rst_ready", ready, 1);
        check("rst_busy",  busy,  0);
        check("rst_done",  done,  0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit rs;
        bit en;
        bit cfg;
        int cg;
        int cs;
        int idle;
        int eg;
        bit er;
        bit eb;
        bit ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit rs, input bit e, input bit c, input int g, input int s,
                                input int idle, input int eg, input bit er, input bit eb, input bit ed);
        vec_t v;
        v.rs = rs; v.en = e; v.cfg = c; v.cg = g; v.cs = s; v.idle = idle;
        v.eg = eg; v.er = er; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    initial begin
        rst = 1'b1; sv = 1'b0; en = 1'b0; cv = 1'b0; cg = '0; cs = '0;
        model_reset();
        #12;
        check("init_gain",  gain,  UNITY_G);
        check("init_ready", ready, 1);
        check("init_busy",  busy,  0);
        check("init_done",  done,  0);
        @(negedge clk);
        rst = 1'b0;

        // Ramp up 16 -> 64 by 8, then two settle strobes
        tbl.push_back(mk(1, 1, 1, 64, 8, 2,  24, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3,   32, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3,   40, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3,   48, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3,   56, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3,   64, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3,   64, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3,   64, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3,   64, 1, 0, 0));
        // Final step clamped onto the target
        tbl.push_back(mk(1, 1, 1, 100, 30, 2, 46, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3,   76, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3,  100, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3,  100, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3,  100, 1, 0, 1));
        // Target above max_gain clamps to 1024
        tbl.push_back(mk(0, 1, 1, 16'hFFFF, 256, 2, 356, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3,  612, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3,  868, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3, 1024, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3, 1024, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3, 1024, 1, 0, 1));
        // Zero step behaves as a step of one
        tbl.push_back(mk(0, 1, 1, 1020, 0, 2, 1023, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3, 1022, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3, 1021, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3, 1020, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3, 1020, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 3, 1020, 1, 0, 1));

        foreach (tbl[i]) begin
            if (tbl[i].rs) do_reset();
            en = tbl[i].en;
            cv = tbl[i].cfg;
            cg = 16'(tbl[i].cg);
            cs = 16'(tbl[i].cs);
            tick();
            cv = 1'b0;
            strobe_wait(tbl[i].idle);
            check($sformatf("tbl%0d_gain", i),  gain,  tbl[i].eg);
            check($sformatf("tbl%0d_ready", i), ready, tbl[i].er);
            check($sformatf("tbl%0d_busy", i),  busy,  tbl[i].eb);
            check($sformatf("tbl%0d_done", i),  done,  tbl[i].ed);
        end

        // Soft bypass: drop enable at 48 while heading to 64
        do_reset();
        en = 1'b1; cv = 1'b1; cg = 16'd64; cs = 16'd8;
        tick();
        cv = 1'b0;
        strobe_wait(2);
        strobe_wait(3);
        strobe_wait(3);
        strobe_wait(3);
        check("byp_start", gain, 48);
        en = 1'b0;
        tick();
        check("byp_flip_busy", busy, 1);
        strobe_wait(2); check("byp_40", gain, 40);
        strobe_wait(3); check("byp_32", gain, 32);
        strobe_wait(3); check("byp_24", gain, 24);
        strobe_wait(3); check("byp_16", gain, 16);
        check("byp_settle_busy", busy, 1);
        strobe_wait(3);
        strobe_wait(3);
        check("byp_done", done, 1);
        check("byp_idle", busy, 0);

        // SETTLE abort, then a request held through a ramp
        do_reset();
        en = 1'b1; cv = 1'b1; cg = 16'd64; cs = 16'd8;
        tick();
        cv = 1'b0;
        strobe_wait(2);
        repeat (5) strobe_wait(3);
        check("abort_at64", gain, 64);
        check("abort_rdy", ready, 1);
        strobe_wait(1);
        cv = 1'b1; cg = 16'd32; cs = 16'd8;
        tick();
        cv = 1'b0;
        strobe_wait(0);
        check("abort_nodone", done, 0);
        check("abort_ramp", ready, 0);
        check("abort_busy", busy, 1);
        check("abort_hold", gain, 64);
        cv = 1'b1; cg = 16'd200; cs = 16'd8;
        strobe_wait(2); check("held_56", gain, 56);
        strobe_wait(3); check("held_48", gain, 48);
        strobe_wait(3); check("held_40", gain, 40);
        strobe_wait(3); check("held_32", gain, 32);
        check("held_rdy", ready, 1);
        tick();
        cv = 1'b0;
        tick();
        check("held_up", ready, 0);
        strobe_wait(1); check("held_up40", gain, 40);

        // Reset mid-ramp: configuration lost, no resume
        do_reset();
        en = 1'b1; cv = 1'b1; cg = 16'd64; cs = 16'd8;
        tick();
        cv = 1'b0;
        strobe_wait(2);
        strobe_wait(3);
        strobe_wait(3);
        check("mid_40", gain, 40);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            strobe_wait(1);
            check("mid_stay", gain, UNITY_G);
            check("mid_idle", busy, 0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            if ($urandom_range(0, 59) == 0) en = ~en;
            cv = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) cg = 16'($urandom);
            else cg = 16'($urandom_range(0, 1100));
            cs = 16'($urandom_range(0, 60));
            sv = ($urandom_range(0, 2) == 0);
            tick();
        end
        sv = 1'b0; cv = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
